hd_class_search: RTL and testbench

- Associative-search stage directly downstream of the class hypervector memory.
- After training writes complete, the block streams every stored class hypervector out of class memory, 16 elements per cycle.
- For each class it computes the signed dot product with the encoded query hypervector.
- It reports the class index with the highest score and that score.

---
 rtl/hd_class_search.sv | 176 +++++++++++++++++
 tb/tb_hd_class_search.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hd_class_search.sv
// ============================================================================
// Module : hd_class_search
// Streams every stored class hypervector, scores each one against the query
// by signed dot product, and reports the best class index and its score.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hd_class_search #(
  parameter int DIM         = 512,
  parameter int LANES       = 16,
  parameter int FTWIDTH     = 8,
  parameter int ADDR_WIDTH  = 13,
  parameter int SCORE_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [4:0]                    class_num,
  input  logic [LANES*FTWIDTH-1:0]      class_out,
  input  logic [LANES*FTWIDTH-1:0]      query_in,
  output logic [ADDR_WIDTH-1:0]         read_address,
  output logic                          re,
  output logic [4:0]                    query_addr,
  output logic                          busy,
  output logic                          done,
  output logic [4:0]                    best_class,
  output logic signed [SCORE_WIDTH-1:0] best_score
);

  localparam int c_CH  = DIM / LANES;
  localparam int c_PW  = 2 * FTWIDTH;
  localparam int c_LSW = c_PW + $clog2(LANES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t                        r_state;
  logic [4:0]                    r_num;
  logic [1:0]                    r_drain;
  logic                          r_v0, r_last0, r_v1, r_last1, r_cmp_v;
  logic signed [c_LSW-1:0]       r_lane;
  logic signed [SCORE_WIDTH-1:0] r_acc, r_cmp_val;
  logic [4:0]                    r_cmp_idx;

  logic signed [c_PW-1:0]        w_prod [LANES];
  logic signed [c_LSW-1:0]       w_lane_sum;
  logic signed [SCORE_WIDTH-1:0] w_acc_next;
  logic [ADDR_WIDTH-1:0]         w_last_addr;
  logic                          w_accept;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign w_prod[j] = $signed(class_out[j*FTWIDTH +: FTWIDTH]) *
                       $signed(query_in[j*FTWIDTH +: FTWIDTH]);
  end

  always_comb begin
    w_lane_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      w_lane_sum = w_lane_sum + {{(c_LSW-c_PW){w_prod[j][c_PW-1]}}, w_prod[j]};
    end
  end

  assign w_acc_next  = r_acc + {{(SCORE_WIDTH-c_LSW){r_lane[c_LSW-1]}}, r_lane};
  assign w_last_addr = ADDR_WIDTH'(r_num) * ADDR_WIDTH'(c_CH) - ADDR_WIDTH'(1);
  // A done pulse coincides with IDLE, so start is also masked by done.
  assign w_accept    = (r_state == S_IDLE) && start && !done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_num        <= '0;
      r_drain      <= '0;
      read_address <= '0;
      re           <= 1'b0;
      query_addr   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_num        <= class_num;
            busy         <= 1'b1;
            read_address <= '0;
            query_addr   <= '0;
            if (class_num == 5'd0) begin
              r_state <= S_FINISH;
            end else begin
              r_state <= S_FETCH;
              re      <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (read_address == w_last_addr) begin
            re      <= 1'b0;
            r_drain <= '0;
            r_state <= S_DRAIN;
          end else begin
            read_address <= read_address + ADDR_WIDTH'(1);
            query_addr   <= (query_addr == 5'(c_CH-1)) ? 5'd0 : query_addr + 5'd1;
          end
        end
        S_DRAIN: begin
          if (r_drain == 2'd2) begin
            r_state <= S_FINISH;
          end else begin
            r_drain <= r_drain + 2'd1;
          end
        end
        default: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath: lane sum -> class accumulator -> best-class compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v0       <= 1'b0;
      r_last0    <= 1'b0;
      r_v1       <= 1'b0;
      r_last1    <= 1'b0;
      r_lane     <= '0;
      r_acc      <= '0;
      r_cmp_v    <= 1'b0;
      r_cmp_val  <= '0;
      r_cmp_idx  <= '0;
      best_class <= '0;
      best_score <= '0;
    end else begin
      r_v0    <= re;
      r_last0 <= re && (query_addr == 5'(c_CH-1));
      r_v1    <= r_v0;
      r_last1 <= r_last0;
      r_lane  <= w_lane_sum;
      r_cmp_v <= 1'b0;
      if (r_v1) begin
        if (r_last1) begin
          r_cmp_v   <= 1'b1;
          r_cmp_val <= w_acc_next;
          r_acc     <= '0;
        end else begin
          r_acc <= w_acc_next;
        end
      end
      if (r_cmp_v) begin
        if ((r_cmp_idx == 5'd0) || (r_cmp_val > best_score)) begin
          best_class <= r_cmp_idx;
          best_score <= r_cmp_val;
        end
        r_cmp_idx <= r_cmp_idx + 5'd1;
      end
      if (w_accept) begin
        r_cmp_idx <= '0;
        r_acc     <= '0;
        if (class_num == 5'd0) begin
          best_class <= '0;
          best_score <= '0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hd_class_search.sv
// ============================================================================
// Module : tb_hd_class_search
// Self-checking bench for hd_class_search against a behavioural argmax model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hd_class_search;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [4:0]        class_num = '0;
  logic [127:0]      class_out = '0;
  logic [127:0]      query_in = '0;
  logic [12:0]       read_address;
  logic              re;
  logic [4:0]        query_addr;
  logic              busy;
  logic              done;
  logic [4:0]        best_class;
  logic signed [31:0] best_score;

  hd_class_search dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .class_num    (class_num),
    .class_out    (class_out),
    .query_in     (query_in),
    .read_address (read_address),
    .re           (re),
    .query_addr   (query_addr),
    .busy         (busy),
    .done         (done),
    .best_class   (best_class),
    .best_score   (best_score)
  );

  always #5 clk = ~clk;

  logic [127:0] mem  [0:1023];
  logic [127:0] qmem [0:31];

  always @(posedge clk) begin
    if (re) class_out <= mem[read_address];
    query_in <= qmem[query_addr];
  end

  int n_cmp = 0;
  int n_fail = 0;
  bit armed = 1'b0;
  int cyc, exp_n, exp_d, exp_addr, done_cyc;
  int exp_cls;
  longint exp_sc;

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Direct argmax over full-length dot products; ties keep the lower index.
  task automatic model(input int n, output int cls, output longint sc);
    logic [127:0] cw, qw;
    longint s;
    cls = 0;
    sc  = 0;
    for (int c = 0; c < n; c++) begin
      s = 0;
      for (int w = 0; w < 32; w++) begin
        cw = mem[c*32+w];
        qw = qmem[w];
        for (int j = 0; j < 16; j++)
          s += longint'($signed(cw[j*8 +: 8])) * longint'($signed(qw[j*8 +: 8]));
      end
      if (c == 0 || s > sc) begin
        cls = c;
        sc  = s;
      end
    end
  endtask

  task automatic set_class(input int c, input int v);
    for (int w = 0; w < 32; w++)
      for (int j = 0; j < 16; j++)
        mem[c*32+w][j*8 +: 8] = 8'(v);
  endtask

  task automatic set_query(input int v);
    for (int w = 0; w < 32; w++)
      for (int j = 0; j < 16; j++)
        qmem[w][j*8 +: 8] = 8'(v);
  endtask

  task automatic randomize_all();
    for (int a = 0; a < 1024; a++)
      mem[a] = {$urandom, $urandom, $urandom, $urandom};
    for (int w = 0; w < 32; w++)
      qmem[w] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("re", longint'(re), longint'(cyc < 32*exp_n));
      if (re) begin
        chk("read_address", longint'(read_address), longint'(exp_addr));
        chk("query_addr", longint'(query_addr), longint'(exp_addr % 32));
        exp_addr++;
      end
      chk("busy", longint'(busy), longint'(cyc < exp_d));
      chk("done", longint'(done), longint'(cyc == exp_d));
      if (done) done_cyc = cyc;
      if (cyc == exp_d) begin
        chk("best_class", longint'(best_class), longint'(exp_cls));
        chk("best_score", longint'(best_score), exp_sc);
        armed = 1'b0;
      end
      cyc++;
    end else if (done) begin
      chk("spurious_done", longint'(done), 0);
    end
  end

  // Launches a search; start is re-pulsed at cycles p1/p2 and reset asserted
  // in cycle rst_at when those are non-negative.
  task automatic run_search(input int n, input int p1, input int p2, input int rst_at);
    model(n, exp_cls, exp_sc);
    repeat (2) @(negedge clk);
    start = 1'b1;
    class_num = 5'(n);
    @(posedge clk);
    #1;
    start     = 1'b0;
    exp_n     = n;
    exp_d     = (n == 0) ? 1 : 32*n + 4;
    exp_addr  = 0;
    done_cyc  = -1;
    cyc       = 0;
    armed     = 1'b1;
    for (int t = 0; t < 2000 && armed; t++) begin
      if (t == rst_at) begin
        armed = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_re", longint'(re), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_best_class", longint'(best_class), 0);
        repeat (900) @(negedge clk);
        break;
      end
      start = (t == p1 || t == p2);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (armed) begin
      chk("done_timeout", 1, 0);
      armed = 1'b0;
    end
  endtask

  initial begin
    int mc;
    longint ms;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_re", longint'(re), 0);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_addr", longint'(read_address), 0);
    chk("reset_qaddr", longint'(query_addr), 0);
    chk("reset_best_score", longint'(best_score), 0);

    // class_num = 0: no reads, done in cycle 1, zero result
    set_query(1);
    for (int c = 0; c < 32; c++) set_class(c, c);
    run_search(0, -1, -1, -1);
    chk("n0_done_cycle", longint'(done_cyc), 1);

    // class c = c, query +1, 26 classes
    model(26, mc, ms);
    chk("model_t1_cls", longint'(mc), 25);
    chk("model_t1_score", ms, 12800);
    run_search(26, -1, -1, -1);
    chk("t1_done_cycle", longint'(done_cyc), 836);
    chk("t1_best_class", longint'(best_class), 25);
    chk("t1_best_score", longint'(best_score), 12800);

    // tie between classes 3 and 7
    for (int c = 0; c < 32; c++) set_class(c, 0);
    set_class(3, 2);
    set_class(7, 2);
    run_search(10, -1, -1, -1);
    chk("tie_best_class", longint'(best_class), 3);
    chk("tie_best_score", longint'(best_score), 1024);

    // all negative: first class must load unconditionally
    for (int c = 0; c < 32; c++) set_class(c, -1);
    run_search(4, -1, -1, -1);
    chk("neg_best_class", longint'(best_class), 0);
    chk("neg_best_score", longint'(best_score), -512);

    // reset mid-search, then a clean rerun
    for (int c = 0; c < 32; c++) set_class(c, c);
    run_search(26, -1, -1, 100);
    run_search(26, -1, -1, -1);
    chk("post_rst_best_class", longint'(best_class), 25);
    chk("post_rst_best_score", longint'(best_score), 12800);

    // start re-pulsed while busy must be ignored
    run_search(26, 5, 500, -1);
    chk("repulse_done_cycle", longint'(done_cyc), 836);

    // randomized contents and class counts
    for (int r = 0; r < 6; r++) begin
      randomize_all();
      run_search(int'($urandom_range(31, 1)), -1, -1, -1);
    end
    randomize_all();
    run_search(31, -1, -1, -1);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
